l2_req_arbiter: RTL and testbench
=================================

// Module: l2_req_arbiter
// PURPOSE
//  N-channel request arbiter and flush sequencer in front of the L2 cache core; successor to the fixed-CPU-count L2 front-end.
//  Round-robin grants one of CH_NUM L1 request channels, forwards it to the cache request port and routes the response back.
//  Adds a range-flush mode: issues one per-line flush request for each line of an address range.
// PARAMETERS
//  CH_NUM      5     number of L1 request channels (1..16)
//  ADDR_BITS   48    request address width
//  LINE_BITS   256   cache line width; STRB_BITS = LINE_BITS/8; LINE_BYTES = LINE_BITS/8
//  TYPE_BITS   4     request type width
//  FLUSH_TYPE  4'hF  request type code driven for flush-line requests
// PORTS
//  i_clk             in   1                  clock
//  i_nrst            in   1                  reset: asynchronous, active LOW
//  i_ch_req_valid    in   CH_NUM             per-channel request valid
//  o_ch_req_ready    out  CH_NUM             per-channel accept (one-hot or zero)
//  i_ch_req_type     in   CH_NUM*TYPE_BITS   packed; channel k at [k*TYPE_BITS +: TYPE_BITS]
//  i_ch_req_addr     in   CH_NUM*ADDR_BITS   packed request address
//  i_ch_req_size     in   CH_NUM*3           packed size
//  i_ch_req_prot     in   CH_NUM*3           packed prot
//  i_ch_req_wdata    in   CH_NUM*LINE_BITS   packed write data
//  i_ch_req_wstrb    in   CH_NUM*STRB_BITS   packed byte strobes
//  o_ch_resp_valid   out  CH_NUM             per-channel response valid (one-hot or zero)
//  i_ch_resp_ready   in   CH_NUM             per-channel response accept
//  o_ch_resp_rdata   out  LINE_BITS          shared response data
//  o_ch_resp_status  out  2                  shared response status
//  o_req_valid       out  1                  cache request valid
//  i_req_ready       in   1                  cache request accept
//  o_req_type/addr/size/prot/wdata/wstrb  out  TYPE_BITS/ADDR_BITS/3/3/LINE_BITS/STRB_BITS  cache request payload
//  i_resp_valid      in   1                  cache response valid (single-cycle pulse)
//  i_resp_rdata      in   LINE_BITS          cache response data
//  i_resp_status     in   2                  cache response status
//  i_flush_valid     in   1                  flush start pulse
//  i_flush_addr      in   ADDR_BITS          flush start address; low log2(LINE_BYTES) bits are forced to 0
//  i_flush_lines     in   16                 number of lines to flush
//  o_flush_busy      out  1                  flush in progress
//  o_flush_end       out  1                  one-cycle pulse when the flush completes
// BEHAVIOUR
//  Reset (async, i_nrst=0): state=IDLE; rr pointer=CH_NUM-1; all outputs 0, including payloads, rdata, status, busy and end.
//  FSM: IDLE -> REQ -> WAIT -> RESP -> IDLE (channel path); IDLE -> FREQ -> FWAIT -> FREQ|IDLE (flush path).
//  IDLE, in priority order:
//   - flush pending -> FREQ.
//   - else if any i_ch_req_valid: grant g = first valid channel after the rr pointer, wrapping modulo CH_NUM.
//     o_ch_req_ready[g]=1 in the same cycle (combinational); payload latched; -> REQ.
//  REQ: o_req_valid=1 with the latched payload held stable until i_req_ready=1 -> WAIT.
//   Earliest o_req_valid is the cycle after the accept.
//  WAIT: on i_resp_valid, latch rdata and status -> RESP.
//  RESP: o_ch_resp_valid[g]=1, held with rdata/status until i_ch_resp_ready[g]=1 -> IDLE; rr pointer<=g.
//   Earliest channel response is the cycle after i_resp_valid.
//  One outstanding request only. o_ch_req_ready is 0 outside IDLE. i_resp_valid outside WAIT/FWAIT is dropped.
//  Flush start:
//   - i_flush_valid while o_flush_busy=0: flush pending, o_flush_busy=1 next cycle, addr=aligned i_flush_addr, cnt=i_flush_lines.
//   - i_flush_valid while o_flush_busy=1: ignored.
//   - A channel transaction already past IDLE completes before the flush begins; the flush preempts only new grants.
//  cnt==0 at start: no cache requests; o_flush_end pulses on the first IDLE cycle; busy drops the same cycle.
//  FREQ: o_req_valid=1, type=FLUSH_TYPE, addr=flush addr, size=3'd5, prot=0, wdata=0, wstrb=0; on i_req_ready -> FWAIT.
//  FWAIT: on i_resp_valid: cnt-=1; addr+=LINE_BYTES, wrapping modulo 2^ADDR_BITS.
//   - cnt becomes 0: o_flush_end=1 for one cycle, o_flush_busy=0 -> IDLE.
//   - else -> FREQ.
//   Flush responses are never forwarded to a channel.
//  Reset mid-operation: in-flight transaction and flush are abandoned. The requester must re-present; no response is replayed.
// TESTING
//  1 Ch2 valid only, addr=0x80001000, type=1 -> ready[2] same cycle; o_req_valid next cycle, addr 0x80001000.
//    After i_resp_valid (rdata=0xA5.., status=0): resp_valid[2] next cycle.
//  2 Chs 0,1,3 valid continuously, instant cache responses -> grant order 0,1,3,0,1,3; no channel starved.
//  3 i_req_ready held 0 for 5 cycles -> o_req_valid and payload stable all 5 cycles; i_ch_resp_ready low 3 cycles -> resp held.
//  4 Flush addr=0x1234, lines=3, LINE_BYTES=32 -> flush requests at 0x1220, 0x1240, 0x1260.
//    o_flush_end pulses once after the 3rd response; no channel resp_valid asserted.
//  5 Flush addr=all-ones, lines=2 -> addrs 0x...FFE0 then 0x0 (wrap); i_flush_lines=0 -> end pulse, no o_req_valid.
//  6 i_nrst low while in WAIT with ch1 granted -> all outputs 0 immediately; after release, ch1 re-request is regranted normally.

Source files
------------

// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter
//   Round-robin arbiter that forwards one L1 channel request at a time to the
//   L2 cache request port and routes the single response back to the granted
//   channel. A range-flush sequencer shares the cache port and issues one
//   flush-line request per cache line of an address range.
//
// Ports
//   i_clk, i_nrst                 clock, async active-low reset
//   i_ch_req_*  / o_ch_req_ready  per-channel request, packed by channel
//   o_ch_resp_* / i_ch_resp_ready per-channel response (valid one-hot)
//   o_req_* / i_req_ready         cache request port
//   i_resp_*                      cache response (single-cycle pulse)
//   i_flush_valid/addr/lines      flush start pulse and range
//   o_flush_busy, o_flush_end     flush status
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting; flush pending takes priority over channel grants
// REQ   | channel request presented on the cache port
// WAIT  | waiting for the cache response to the channel request
// RESP  | response presented to the granted channel
// FREQ  | flush-line request presented on the cache port
// FWAIT | waiting for the flush-line response
module l2_req_arbiter #(
  parameter int              CH_NUM     = 5,
  parameter int              ADDR_BITS  = 48,
  parameter int              LINE_BITS  = 256,
  parameter int              TYPE_BITS  = 4,
  parameter logic [TYPE_BITS-1:0] FLUSH_TYPE = 4'hF
) (
  input  logic                          i_clk,
  input  logic                          i_nrst,
  input  logic [CH_NUM-1:0]             i_ch_req_valid,
  output logic [CH_NUM-1:0]             o_ch_req_ready,
  input  logic [CH_NUM*TYPE_BITS-1:0]   i_ch_req_type,
  input  logic [CH_NUM*ADDR_BITS-1:0]   i_ch_req_addr,
  input  logic [CH_NUM*3-1:0]           i_ch_req_size,
  input  logic [CH_NUM*3-1:0]           i_ch_req_prot,
  input  logic [CH_NUM*LINE_BITS-1:0]   i_ch_req_wdata,
  input  logic [CH_NUM*LINE_BITS/8-1:0] i_ch_req_wstrb,
  output logic [CH_NUM-1:0]             o_ch_resp_valid,
  input  logic [CH_NUM-1:0]             i_ch_resp_ready,
  output logic [LINE_BITS-1:0]          o_ch_resp_rdata,
  output logic [1:0]                    o_ch_resp_status,
  output logic                          o_req_valid,
  input  logic                          i_req_ready,
  output logic [TYPE_BITS-1:0]          o_req_type,
  output logic [ADDR_BITS-1:0]          o_req_addr,
  output logic [2:0]                    o_req_size,
  output logic [2:0]                    o_req_prot,
  output logic [LINE_BITS-1:0]          o_req_wdata,
  output logic [LINE_BITS/8-1:0]        o_req_wstrb,
  input  logic                          i_resp_valid,
  input  logic [LINE_BITS-1:0]          i_resp_rdata,
  input  logic [1:0]                    i_resp_status,
  input  logic                          i_flush_valid,
  input  logic [ADDR_BITS-1:0]          i_flush_addr,
  input  logic [15:0]                   i_flush_lines,
  output logic                          o_flush_busy,
  output logic                          o_flush_end
);

  localparam int STRB_BITS  = LINE_BITS / 8;
  localparam int LINE_BYTES = LINE_BITS / 8;
  localparam int IDX_BITS   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    FREQ  = 3'd4,
    FWAIT = 3'd5
  } state_t;

  state_t                state;
  logic [IDX_BITS-1:0]   rr_ptr;
  logic [IDX_BITS-1:0]   gnt_reg;
  logic [ADDR_BITS-1:0]  flush_addr;
  logic [15:0]           flush_cnt;

  logic                  gnt_any;
  logic [IDX_BITS-1:0]   gnt_idx;
  int                    cand;

  logic [ADDR_BITS-1:0]  flush_addr_aligned;
  logic [ADDR_BITS-1:0]  flush_addr_next;

  // Scan from farthest to nearest so the last hit is the first valid
  // channel after the round-robin pointer.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = CH_NUM; k >= 1; k--) begin
      cand = (int'(rr_ptr) + k) % CH_NUM;
      if (i_ch_req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_BITS'(cand);
      end
    end
  end

  // A pending flush blocks new grants; reset also masks the accept so
  // nothing is handshaken while the block is held in reset.
  assign o_ch_req_ready = (i_nrst && state == IDLE && !o_flush_busy && gnt_any)
                          ? (CH_NUM'(1) << gnt_idx) : '0;

  assign flush_addr_aligned = i_flush_addr & ~ADDR_BITS'(LINE_BYTES - 1);
  assign flush_addr_next    = flush_addr + ADDR_BITS'(LINE_BYTES);

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state            <= IDLE;
      rr_ptr           <= IDX_BITS'(CH_NUM - 1);
      gnt_reg          <= '0;
      flush_addr       <= '0;
      flush_cnt        <= '0;
      o_ch_resp_valid  <= '0;
      o_ch_resp_rdata  <= '0;
      o_ch_resp_status <= '0;
      o_req_valid      <= 1'b0;
      o_req_type       <= '0;
      o_req_addr       <= '0;
      o_req_size       <= '0;
      o_req_prot       <= '0;
      o_req_wdata      <= '0;
      o_req_wstrb      <= '0;
      o_flush_busy     <= 1'b0;
      o_flush_end      <= 1'b0;
    end else begin
      o_flush_end <= 1'b0;

      case (state)
        IDLE: begin
          if (o_flush_busy) begin
            if (flush_cnt == 16'd0) begin
              o_flush_busy <= 1'b0;
              o_flush_end  <= 1'b1;
            end else begin
              state       <= FREQ;
              o_req_valid <= 1'b1;
              o_req_type  <= FLUSH_TYPE;
              o_req_addr  <= flush_addr;
              o_req_size  <= 3'd5;
              o_req_prot  <= '0;
              o_req_wdata <= '0;
              o_req_wstrb <= '0;
            end
          end else if (gnt_any) begin
            state       <= REQ;
            gnt_reg     <= gnt_idx;
            o_req_valid <= 1'b1;
            o_req_type  <= i_ch_req_type[int'(gnt_idx)*TYPE_BITS +: TYPE_BITS];
            o_req_addr  <= i_ch_req_addr[int'(gnt_idx)*ADDR_BITS +: ADDR_BITS];
            o_req_size  <= i_ch_req_size[int'(gnt_idx)*3 +: 3];
            o_req_prot  <= i_ch_req_prot[int'(gnt_idx)*3 +: 3];
            o_req_wdata <= i_ch_req_wdata[int'(gnt_idx)*LINE_BITS +: LINE_BITS];
            o_req_wstrb <= i_ch_req_wstrb[int'(gnt_idx)*STRB_BITS +: STRB_BITS];
          end
        end

        REQ: begin
          if (i_req_ready) begin
            o_req_valid <= 1'b0;
            state       <= WAIT;
          end
        end

        WAIT: begin
          if (i_resp_valid) begin
            o_ch_resp_rdata  <= i_resp_rdata;
            o_ch_resp_status <= i_resp_status;
            o_ch_resp_valid  <= CH_NUM'(1) << gnt_reg;
            state            <= RESP;
          end
        end

        RESP: begin
          if (i_ch_resp_ready[gnt_reg]) begin
            o_ch_resp_valid <= '0;
            rr_ptr          <= gnt_reg;
            state           <= IDLE;
          end
        end

        FREQ: begin
          if (i_req_ready) begin
            o_req_valid <= 1'b0;
            state       <= FWAIT;
          end
        end

        FWAIT: begin
          if (i_resp_valid) begin
            flush_cnt  <= flush_cnt - 16'd1;
            flush_addr <= flush_addr_next;
            if (flush_cnt == 16'd1) begin
              o_flush_busy <= 1'b0;
              o_flush_end  <= 1'b1;
              state        <= IDLE;
            end else begin
              o_req_valid <= 1'b1;
              o_req_addr  <= flush_addr_next;
              state       <= FREQ;
            end
          end
        end

        default: state <= IDLE;
      endcase

      // Only accepted while idle in flush terms, so it never collides with
      // the sequencer's own updates of busy/addr/cnt above.
      if (i_flush_valid && !o_flush_busy) begin
        o_flush_busy <= 1'b1;
        flush_addr   <= flush_addr_aligned;
        flush_cnt    <= i_flush_lines;
      end
    end
  end

endmodule

// File: tb/tb_l2_req_arbiter.sv
module tb_l2_req_arbiter;

  localparam int CH   = 5;
  localparam int AB   = 48;
  localparam int LB   = 256;
  localparam int TB   = 4;
  localparam int SB   = LB / 8;

  logic                i_clk = 1'b0;
  logic                i_nrst;
  logic [CH-1:0]       i_ch_req_valid;
  logic [CH-1:0]       o_ch_req_ready;
  logic [CH*TB-1:0]    i_ch_req_type;
  logic [CH*AB-1:0]    i_ch_req_addr;
  logic [CH*3-1:0]     i_ch_req_size;
  logic [CH*3-1:0]     i_ch_req_prot;
  logic [CH*LB-1:0]    i_ch_req_wdata;
  logic [CH*SB-1:0]    i_ch_req_wstrb;
  logic [CH-1:0]       o_ch_resp_valid;
  logic [CH-1:0]       i_ch_resp_ready;
  logic [LB-1:0]       o_ch_resp_rdata;
  logic [1:0]          o_ch_resp_status;
  logic                o_req_valid;
  logic                i_req_ready;
  logic [TB-1:0]       o_req_type;
  logic [AB-1:0]       o_req_addr;
  logic [2:0]          o_req_size;
  logic [2:0]          o_req_prot;
  logic [LB-1:0]       o_req_wdata;
  logic [SB-1:0]       o_req_wstrb;
  logic                i_resp_valid;
  logic [LB-1:0]       i_resp_rdata;
  logic [1:0]          i_resp_status;
  logic                i_flush_valid;
  logic [AB-1:0]       i_flush_addr;
  logic [15:0]         i_flush_lines;
  logic                o_flush_busy;
  logic                o_flush_end;

  int total = 0;
  int bad   = 0;
  int end_cnt = 0;
  int chresp_cnt = 0;
  int reqv_cnt = 0;

  l2_req_arbiter dut (
    .i_clk(i_clk), .i_nrst(i_nrst),
    .i_ch_req_valid(i_ch_req_valid), .o_ch_req_ready(o_ch_req_ready),
    .i_ch_req_type(i_ch_req_type), .i_ch_req_addr(i_ch_req_addr),
    .i_ch_req_size(i_ch_req_size), .i_ch_req_prot(i_ch_req_prot),
    .i_ch_req_wdata(i_ch_req_wdata), .i_ch_req_wstrb(i_ch_req_wstrb),
    .o_ch_resp_valid(o_ch_resp_valid), .i_ch_resp_ready(i_ch_resp_ready),
    .o_ch_resp_rdata(o_ch_resp_rdata), .o_ch_resp_status(o_ch_resp_status),
    .o_req_valid(o_req_valid), .i_req_ready(i_req_ready),
    .o_req_type(o_req_type), .o_req_addr(o_req_addr), .o_req_size(o_req_size),
    .o_req_prot(o_req_prot), .o_req_wdata(o_req_wdata), .o_req_wstrb(o_req_wstrb),
    .i_resp_valid(i_resp_valid), .i_resp_rdata(i_resp_rdata),
    .i_resp_status(i_resp_status),
    .i_flush_valid(i_flush_valid), .i_flush_addr(i_flush_addr),
    .i_flush_lines(i_flush_lines),
    .o_flush_busy(o_flush_busy), .o_flush_end(o_flush_end)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_flush_end)      end_cnt++;
    if (|o_ch_resp_valid) chresp_cnt++;
    if (o_req_valid)      reqv_cnt++;
  end

  task automatic check(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [TB-1:0] t, input logic [AB-1:0] a,
                        input logic [LB-1:0] wd);
    i_ch_req_type[k*TB +: TB]  = t;
    i_ch_req_addr[k*AB +: AB]  = a;
    i_ch_req_size[k*3 +: 3]    = 3'd2;
    i_ch_req_prot[k*3 +: 3]    = 3'd1;
    i_ch_req_wdata[k*LB +: LB] = wd;
    i_ch_req_wstrb[k*SB +: SB] = '1;
  endtask

  // Waits (bounded) for a flush-line request and checks its fixed fields.
  task automatic wait_flush_req(input string tag, input logic [AB-1:0] exp_addr);
    for (int i = 0; i < 20 && !o_req_valid; i++) tick();
    check({tag, "_seen"}, LB'(o_req_valid), LB'(1));
    check({tag, "_addr"}, LB'(o_req_addr), LB'(exp_addr));
    check({tag, "_type"}, LB'(o_req_type), LB'(4'hF));
    check({tag, "_size"}, LB'(o_req_size), LB'(3'd5));
    check({tag, "_wstrb"}, LB'(o_req_wstrb), LB'(0));
    i_req_ready = 1'b1;
    tick();
    i_req_ready  = 1'b0;
    i_resp_valid = 1'b1;
    tick();
    i_resp_valid = 1'b0;
  endtask

  int grants[6];
  int ng;
  int snap_end, snap_resp, snap_reqv;
  logic [LB-1:0] rd_a5, rd_5a;

  initial begin
    i_nrst = 1'b0;
    i_ch_req_valid = '0; i_ch_req_type = '0; i_ch_req_addr = '0;
    i_ch_req_size = '0; i_ch_req_prot = '0; i_ch_req_wdata = '0; i_ch_req_wstrb = '0;
    i_ch_resp_ready = '0; i_req_ready = 1'b0; i_resp_valid = 1'b0;
    i_resp_rdata = '0; i_resp_status = '0;
    i_flush_valid = 1'b0; i_flush_addr = '0; i_flush_lines = '0;
    rd_a5 = {32{8'hA5}};
    rd_5a = {32{8'h5A}};

    // reset state
    #1;
    check("rst_req_valid", LB'(o_req_valid), LB'(0));
    check("rst_req_addr", LB'(o_req_addr), LB'(0));
    check("rst_ch_ready", LB'(o_ch_req_ready), LB'(0));
    check("rst_resp_valid", LB'(o_ch_resp_valid), LB'(0));
    check("rst_busy", LB'(o_flush_busy), LB'(0));
    check("rst_end", LB'(o_flush_end), LB'(0));
    tick(); tick();
    i_nrst = 1'b1;
    tick();

    // round robin over channels 0,1,3 with an instant cache
    set_ch(0, 4'd1, 48'h100, '0);
    set_ch(1, 4'd1, 48'h200, '0);
    set_ch(3, 4'd1, 48'h300, '0);
    i_ch_req_valid  = 5'b01011;
    i_req_ready     = 1'b1;
    i_resp_valid    = 1'b1;
    i_ch_resp_ready = '1;
    #1;
    ng = 0;
    for (int cyc = 0; cyc < 60 && ng < 6; cyc++) begin
      if (|o_ch_req_ready) begin
        check("rr_onehot", LB'($onehot(o_ch_req_ready)), LB'(1));
        for (int b = 0; b < CH; b++) if (o_ch_req_ready[b]) grants[ng] = b;
        ng++;
      end
      tick();
    end
    i_ch_req_valid = '0;
    check("rr_count", LB'(ng), LB'(6));
    check("rr_g0", LB'(grants[0]), LB'(0));
    check("rr_g1", LB'(grants[1]), LB'(1));
    check("rr_g2", LB'(grants[2]), LB'(3));
    check("rr_g3", LB'(grants[3]), LB'(0));
    check("rr_g4", LB'(grants[4]), LB'(1));
    check("rr_g5", LB'(grants[5]), LB'(3));
    tick(); tick(); tick(); tick();
    i_req_ready = 1'b0; i_resp_valid = 1'b0; i_ch_resp_ready = '0;
    tick();
    check("rr_idle_after", LB'(o_req_valid), LB'(0));

    // single request on channel 2
    set_ch(2, 4'd1, 48'h8000_1000, {8{32'hDEAD_BEEF}});
    i_ch_req_valid = 5'b00100;
    #1;
    check("t1_ready", LB'(o_ch_req_ready), LB'(5'b00100));
    check("t1_no_req_yet", LB'(o_req_valid), LB'(0));
    tick();
    i_ch_req_valid = '0;
    check("t1_req_valid", LB'(o_req_valid), LB'(1));
    check("t1_req_addr", LB'(o_req_addr), LB'(48'h8000_1000));
    check("t1_req_type", LB'(o_req_type), LB'(4'd1));
    check("t1_req_wdata", o_req_wdata, {8{32'hDEAD_BEEF}});
    check("t1_ready_busy", LB'(o_ch_req_ready), LB'(0));
    i_req_ready = 1'b1;
    tick();
    i_req_ready = 1'b0;
    check("t1_req_dropped", LB'(o_req_valid), LB'(0));
    i_resp_valid = 1'b1; i_resp_rdata = rd_a5; i_resp_status = 2'd0;
    tick();
    i_resp_valid = 1'b0; i_resp_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      check("t1_resp_valid", LB'(o_ch_resp_valid), LB'(5'b00100));
      check("t1_resp_rdata", o_ch_resp_rdata, rd_a5);
      tick();
    end
    i_ch_resp_ready = 5'b00100;
    tick();
    i_ch_resp_ready = '0;
    check("t1_resp_done", LB'(o_ch_resp_valid), LB'(0));

    // stall on the cache port with a request from channel 0
    set_ch(0, 4'd2, 48'h40, '0);
    i_ch_req_valid = 5'b00001;
    #1;
    check("t3_ready", LB'(o_ch_req_ready), LB'(5'b00001));
    tick();
    i_ch_req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      check("t3_stall_valid", LB'(o_req_valid), LB'(1));
      check("t3_stall_addr", LB'(o_req_addr), LB'(48'h40));
      check("t3_stall_type", LB'(o_req_type), LB'(4'd2));
      tick();
    end
    i_req_ready = 1'b1;
    tick();
    i_req_ready = 1'b0;
    i_resp_valid = 1'b1; i_resp_rdata = LB'(64'h1122_3344); i_resp_status = 2'd3;
    tick();
    i_resp_valid = 1'b0;
    check("t3_resp_status", LB'(o_ch_resp_status), LB'(2'd3));
    i_ch_resp_ready = 5'b00001;
    tick();
    i_ch_resp_ready = '0;

    // flush of three lines from an unaligned address
    snap_end = end_cnt; snap_resp = chresp_cnt;
    i_flush_valid = 1'b1; i_flush_addr = 48'h1234; i_flush_lines = 16'd3;
    tick();
    i_flush_valid = 1'b0;
    check("t4_busy", LB'(o_flush_busy), LB'(1));
    wait_flush_req("t4_l0", 48'h1220);
    check("t4_busy_mid", LB'(o_flush_busy), LB'(1));
    wait_flush_req("t4_l1", 48'h1240);
    wait_flush_req("t4_l2", 48'h1260);
    check("t4_end", LB'(o_flush_end), LB'(1));
    check("t4_busy_off", LB'(o_flush_busy), LB'(0));
    tick();
    check("t4_end_low", LB'(o_flush_end), LB'(0));
    check("t4_end_count", LB'(end_cnt - snap_end), LB'(1));
    check("t4_no_ch_resp", LB'(chresp_cnt - snap_resp), LB'(0));

    // flush wrapping the top of the address space
    i_flush_valid = 1'b1; i_flush_addr = '1; i_flush_lines = 16'd2;
    tick();
    i_flush_valid = 1'b0;
    wait_flush_req("t5_l0", 48'hFFFF_FFFF_FFE0);
    wait_flush_req("t5_l1", 48'h0);
    check("t5_end", LB'(o_flush_end), LB'(1));
    tick();

    // zero-length flush
    snap_reqv = reqv_cnt; snap_end = end_cnt;
    i_flush_valid = 1'b1; i_flush_addr = 48'h4000; i_flush_lines = 16'd0;
    tick();
    i_flush_valid = 1'b0;
    check("t5z_busy", LB'(o_flush_busy), LB'(1));
    tick();
    check("t5z_end", LB'(o_flush_end), LB'(1));
    check("t5z_busy_off", LB'(o_flush_busy), LB'(0));
    tick(); tick();
    check("t5z_end_count", LB'(end_cnt - snap_end), LB'(1));
    check("t5z_no_req", LB'(reqv_cnt - snap_reqv), LB'(0));

    // reset while channel 1 waits for its response
    set_ch(1, 4'd3, 48'h2000, '0);
    i_ch_req_valid = 5'b00010;
    #1;
    check("t6_ready", LB'(o_ch_req_ready), LB'(5'b00010));
    tick();
    i_req_ready = 1'b1;
    tick();
    i_req_ready = 1'b0;
    check("t6_addr_held", LB'(o_req_addr), LB'(48'h2000));
    i_nrst = 1'b0;
    #1;
    check("t6_rst_addr", LB'(o_req_addr), LB'(0));
    check("t6_rst_type", LB'(o_req_type), LB'(0));
    check("t6_rst_ready", LB'(o_ch_req_ready), LB'(0));
    check("t6_rst_resp", LB'(o_ch_resp_valid), LB'(0));
    tick();
    i_nrst = 1'b1;
    #1;
    check("t6_regrant", LB'(o_ch_req_ready), LB'(5'b00010));
    tick();
    i_ch_req_valid = '0;
    check("t6_req_valid", LB'(o_req_valid), LB'(1));
    check("t6_req_addr", LB'(o_req_addr), LB'(48'h2000));
    i_req_ready = 1'b1;
    tick();
    i_req_ready = 1'b0;
    check("t6_no_replay", LB'(o_ch_resp_valid), LB'(0));
    i_resp_valid = 1'b1; i_resp_rdata = rd_5a; i_resp_status = 2'd1;
    tick();
    i_resp_valid = 1'b0;
    check("t6_resp_valid", LB'(o_ch_resp_valid), LB'(5'b00010));
    check("t6_resp_rdata", o_ch_resp_rdata, rd_5a);
    check("t6_resp_status", LB'(o_ch_resp_status), LB'(2'd1));
    i_ch_resp_ready = 5'b00010;
    tick();
    i_ch_resp_ready = '0;
    check("t6_resp_done", LB'(o_ch_resp_valid), LB'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
